// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-cache miss handling path:
// FSM state encoding, word size and cache-line address alignment.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    COMMIT
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Widest address line_align() accepts; callers size-cast in and out.
  localparam int unsigned MAX_ADDR_W = 64;

  // Clears the byte-offset-within-line bits of a byte address.
  function automatic logic [MAX_ADDR_W-1:0] line_align(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           line_words
  );
    logic [MAX_ADDR_W-1:0] line_bytes;
    line_bytes = MAX_ADDR_W'(line_words * WORD_BYTES);
    return addr & ~(line_bytes - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/line_beat_counter.sv
// Word index within a cache line, shared by the write-back and refill
// phases. Wraps to 0 after the last word of the line.
module line_beat_counter #(
  parameter  int unsigned LINE_WORDS = 4,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              increment,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  logic [BEAT_W-1:0] beat_q, beat_d;

  // Next beat: clear has priority over increment; natural wrap at the line end.
  always_comb begin
    // NOTE: assign a default first so every path writes beat_d and no latch is inferred.
    beat_d = beat_q;
    if (clear) begin
      beat_d = '0;
    end else if (increment) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // Beat register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/miss_stall_controller.sv
// Data-cache miss sequencer for LW/SW: freezes the core on a miss, writes
// back a dirty victim line, refills the missing line word by word, then
// commits the line and releases the stall.
// Optional feature macro: MISS_STALL_PERF_EN adds miss/write-back counters.
module miss_stall_controller
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned ADDR_W     = 32,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              cache_hit,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic              halted,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  output logic [BEAT_W-1:0] word_sel,
  output logic              fill_we,
  output logic              line_commit
`ifdef MISS_STALL_PERF_EN
  ,
  output logic [31:0]       perf_miss_cnt,
  output logic [31:0]       perf_wb_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic [ADDR_W-1:0] vic_base_q, vic_base_d;

  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic              beat_clear;
  logic              beat_incr;
  logic              miss_detect;
  logic [ADDR_W-1:0] beat_offset;

  // A new miss is only accepted while the core is running.
  assign miss_detect = acc_valid & ~cache_hit & ~halted;
  assign beat_offset = ADDR_W'(beat) * ADDR_W'(WORD_BYTES);

  line_beat_counter #(
    .LINE_WORDS(LINE_WORDS)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .clear    (beat_clear),
    .increment(beat_incr),
    .beat     (beat),
    .last     (beat_last)
  );

  // Next-state, address latches and all memory/cache outputs.
  always_comb begin
    state_d     = state_q;
    miss_base_d = miss_base_q;
    vic_base_d  = vic_base_q;
    beat_clear  = 1'b0;
    beat_incr   = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    word_sel    = '0;
    fill_we     = 1'b0;
    line_commit = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = miss_detect;
        if (miss_detect) begin
          miss_base_d = ADDR_W'(line_align(MAX_ADDR_W'(acc_addr), LINE_WORDS));
          vic_base_d  = ADDR_W'(line_align(MAX_ADDR_W'(victim_addr), LINE_WORDS));
          beat_clear  = 1'b1;
          state_d     = victim_dirty ? WB : FILL;
        end
      end

      WB: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = vic_base_q + beat_offset;
        word_sel = beat;
        if (mem_done) begin
          // The counter wraps to 0 on the last word, ready for the refill.
          beat_incr = 1'b1;
          if (beat_last) begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = miss_base_q + beat_offset;
        word_sel = beat;
        fill_we  = mem_done;
        if (mem_done) begin
          beat_incr = 1'b1;
          if (beat_last) begin
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        stall       = 1'b1;
        line_commit = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched line bases; reset abandons any miss in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_base_q <= '0;
      vic_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_base_q <= miss_base_d;
      vic_base_q  <= vic_base_d;
    end
  end

`ifdef MISS_STALL_PERF_EN
  logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;
  logic [31:0] perf_wb_cnt_q, perf_wb_cnt_d;

  // Count accepted misses and those that needed a victim write-back.
  always_comb begin
    perf_miss_cnt_d = perf_miss_cnt_q;
    perf_wb_cnt_d   = perf_wb_cnt_q;
    if ((state_q == IDLE) && miss_detect) begin
      perf_miss_cnt_d = perf_miss_cnt_q + 32'd1;
      if (victim_dirty) begin
        perf_wb_cnt_d = perf_wb_cnt_q + 32'd1;
      end
    end
  end

  // Performance counter registers, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cnt_q <= '0;
      perf_wb_cnt_q   <= '0;
    end else begin
      perf_miss_cnt_q <= perf_miss_cnt_d;
      perf_wb_cnt_q   <= perf_wb_cnt_d;
    end
  end

  assign perf_miss_cnt = perf_miss_cnt_q;
  assign perf_wb_cnt   = perf_wb_cnt_q;
`endif

endmodule

// File: tb/tb_miss_stall_controller.sv
// Self-checking bench for miss_stall_controller (LINE_WORDS=4, ADDR_W=32).
module tb_miss_stall_controller;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          acc_valid;
  logic [AW-1:0] acc_addr;
  logic          cache_hit;
  logic          victim_dirty;
  logic [AW-1:0] victim_addr;
  logic          halted;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_done;
  logic [BW-1:0] word_sel;
  logic          fill_we;
  logic          line_commit;
`ifdef MISS_STALL_PERF_EN
  logic [31:0]   perf_miss_cnt;
  logic [31:0]   perf_wb_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] sel;
  } xfer_t;

  xfer_t sb_q[$];

  typedef struct {
    logic av, hit, dirty, halt;
    logic exp_stall;
    logic exp_next_req;
    logic exp_next_we;
  } vec_t;

  miss_stall_controller #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .acc_valid   (acc_valid),
    .acc_addr    (acc_addr),
    .cache_hit   (cache_hit),
    .victim_dirty(victim_dirty),
    .victim_addr (victim_addr),
    .halted      (halted),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .word_sel    (word_sel),
    .fill_we     (fill_we),
    .line_commit (line_commit)
`ifdef MISS_STALL_PERF_EN
    ,
    .perf_miss_cnt(perf_miss_cnt),
    .perf_wb_cnt  (perf_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one miss with a memory that answers after 'waits' idle cycles per word.
  task automatic run_miss(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] vaddr,
                          input logic dirty, input int waits, input int exp_stall);
    logic [AW-1:0] mb, vb, held_addr;
    logic          held_we;
    logic          in_req;
    int            stall_cycles, commits, wait_cnt, cyc;
    bit            done;
    xfer_t         exp;
`ifdef MISS_STALL_PERF_EN
    logic [31:0]   miss0, wb0;
    miss0 = perf_miss_cnt;
    wb0   = perf_wb_cnt;
`endif
    mb = addr & ~AW'(LW * 4 - 1);
    vb = vaddr & ~AW'(LW * 4 - 1);
    sb_q.delete();
    if (dirty) begin
      for (int i = 0; i < LW; i++) sb_q.push_back('{1'b1, vb + AW'(4 * i), BW'(i)});
    end
    for (int i = 0; i < LW; i++) sb_q.push_back('{1'b0, mb + AW'(4 * i), BW'(i)});

    stall_cycles = 0; commits = 0; wait_cnt = 0; cyc = 0; done = 0; in_req = 0;
    held_addr = '0; held_we = 1'b0;
    @(negedge clk);
    acc_addr = addr; victim_addr = vaddr; victim_dirty = dirty;
    cache_hit = 1'b0; acc_valid = 1'b1; mem_done = 1'b0;
    while (!done && cyc < 200) begin
      #1;
      if (stall) stall_cycles++;
      else done = 1;
      if (line_commit) commits++;
      if (mem_req) begin
        if (in_req) begin
          check({tag, " addr hold"}, mem_addr, held_addr);
          check({tag, " we hold"}, mem_we, held_we);
        end else begin
          held_addr = mem_addr;
          held_we   = mem_we;
          in_req    = 1'b1;
        end
        if (wait_cnt == waits) begin
          mem_done = 1'b1;
          #1;
          check({tag, " fill_we"}, fill_we, !mem_we);
          if (sb_q.size() == 0) begin
            check({tag, " unexpected xfer"}, 1, 0);
          end else begin
            exp = sb_q.pop_front();
            check({tag, " mem_we"}, mem_we, exp.we);
            check({tag, " mem_addr"}, mem_addr, exp.addr);
            check({tag, " word_sel"}, word_sel, exp.sel);
          end
          wait_cnt = 0;
          in_req   = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
      mem_done = 1'b0;
      if (commits > 0) cache_hit = 1'b1;
      cyc++;
    end
    check({tag, " finished in budget"}, done, 1);
    check({tag, " stall cycles"}, stall_cycles, exp_stall);
    check({tag, " commit pulses"}, commits, 1);
    check({tag, " xfers left"}, sb_q.size(), 0);
`ifdef MISS_STALL_PERF_EN
    check({tag, " perf_miss_cnt"}, perf_miss_cnt, miss0 + 32'd1);
    check({tag, " perf_wb_cnt"}, perf_wb_cnt, wb0 + 32'(dirty));
`endif
    acc_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    rst = 1'b1; acc_valid = 1'b0; acc_addr = '0; cache_hit = 1'b0;
    victim_dirty = 1'b0; victim_addr = '0; halted = 1'b0; mem_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset stall", stall, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset word_sel", word_sel, 0);
    check("reset fill_we", fill_we, 0);
    check("reset line_commit", line_commit, 0);
`ifdef MISS_STALL_PERF_EN
    check("reset perf_miss_cnt", perf_miss_cnt, 0);
    check("reset perf_wb_cnt", perf_wb_cnt, 0);
`endif

    // IDLE decode table: {av, hit, dirty, halt, stall, next mem_req, next mem_we}
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 1, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[4] = '{1, 0, 1, 0, 1, 1, 1};
    vecs[5] = '{1, 0, 1, 1, 0, 0, 0};
    vecs[6] = '{0, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{1, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc_valid = vecs[i].av; cache_hit = vecs[i].hit;
      victim_dirty = vecs[i].dirty; halted = vecs[i].halt;
      acc_addr = 32'h0000_1234; victim_addr = 32'h0000_8008;
      #1;
      check($sformatf("vec%0d stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d idle mem_req", i), mem_req, 0);
      check($sformatf("vec%0d idle mem_addr", i), mem_addr, 0);
      @(negedge clk);
      acc_valid = 1'b0; halted = 1'b0;
      #1;
      check($sformatf("vec%0d next mem_req", i), mem_req, vecs[i].exp_next_req);
      check($sformatf("vec%0d next mem_we", i), mem_we, vecs[i].exp_next_we);
      pulse_reset();
    end

    // Sustained hit: no stall and no memory traffic.
    @(negedge clk);
    acc_valid = 1'b1; cache_hit = 1'b1; acc_addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hit stall", stall, 0);
      check("hit mem_req", mem_req, 0);
      @(negedge clk);
    end
    acc_valid = 1'b0;

    run_miss("clean", 32'h0000_1234, 32'h0000_5000, 1'b0, 0, 6);
    run_miss("dirty", 32'h0000_0040, 32'h0000_8008, 1'b1, 0, 10);
    run_miss("slow", 32'h0000_1234, 32'h0000_5000, 1'b0, 3, 18);
    run_miss("dirty slow", 32'h0000_0A5C, 32'h0000_FFF4, 1'b1, 1, 18);

    // Reset during refill beat 2: back to IDLE, no commit.
    @(negedge clk);
    acc_addr = 32'h0000_2000; victim_dirty = 1'b0; cache_hit = 1'b0;
    acc_valid = 1'b1; mem_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst-mid word_sel", word_sel, 2);
    check("rst-mid mem_addr", mem_addr, 32'h0000_2008);
    rst = 1'b1; acc_valid = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst-mid stall", stall, 0);
    check("rst-mid mem_req", mem_req, 0);
    check("rst-mid mem_we", mem_we, 0);
    check("rst-mid mem_addr", mem_addr, 0);
    check("rst-mid word_sel", word_sel, 0);
    check("rst-mid fill_we", fill_we, 0);
    for (int i = 0; i < 4; i++) begin
      check("rst-mid line_commit", line_commit, 0);
      @(negedge clk);
      #1;
    end

    // Halted core with a miss presented: nothing happens.
    begin
`ifdef MISS_STALL_PERF_EN
      logic [31:0] miss0;
      miss0 = perf_miss_cnt;
`endif
      @(negedge clk);
      acc_valid = 1'b1; cache_hit = 1'b0; halted = 1'b1; acc_addr = 32'h0000_3000;
      for (int i = 0; i < 3; i++) begin
        #1;
        check("halted stall", stall, 0);
        check("halted mem_req", mem_req, 0);
        @(negedge clk);
      end
`ifdef MISS_STALL_PERF_EN
      check("halted perf_miss_cnt", perf_miss_cnt, miss0);
`endif
      acc_valid = 1'b0; halted = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
